// File: rtl/fft_feed_pkg.sv
// Shared definitions for the FFT frame feeder: controller states, data-lane
// bit positions and the offset-binary to Q15 sample conversion.
package fft_feed_pkg;

    typedef enum logic [1:0] {
        ST_CFG  = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    // Bit positions of the real and imaginary halves of the 32-bit data lane.
    localparam int RE_LSB = 0;
    localparam int IM_LSB = 16;

    // Offset-binary sample (zero-extended to 16 bits, 'width' significant bits)
    // to signed Q15: flip the sign bit, then left-justify into 16 bits.
    function automatic logic [15:0] adc_to_q15(input logic [15:0] adc, input int width);
        return (adc ^ (16'h0001 << (width - 1))) << (16 - width);
    endfunction

endpackage

// File: rtl/fft_feed_skid.sv
// Two-entry valid/ready output register. Absorbs the one-cycle read latency
// of the frame RAM so the stream runs at one beat per cycle; 'count' lets the
// producer issue reads only when a slot is guaranteed.
module fft_feed_skid #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign push      = in_valid;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = head;

    // Head is the presented beat; tail only fills while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Captures one frame of ADC samples, converts them to Q15 complex with a zero
// imaginary part and streams the frame to the FFT over AXI4-Stream, honouring
// tready. Issues the FFT direction config once after every reset.
module fft_frame_feeder #(
    parameter int   ADC_WIDTH    = 8,
    parameter int   LOGS_FFT_LEN = 10,
    parameter logic FFT_DIR      = 1'b1
) (
    input  logic                 i_aclk,
    input  logic                 i_rst,
    input  logic [ADC_WIDTH-1:0] i_adc_data,
    input  logic                 i_adc_vld,
    input  logic                 i_start,
    input  logic                 i_continuous,
    output logic                 o_axi4s_cfg_tvalid,
    output logic                 o_axi4s_cfg_tdata,
    output logic                 o_axi4s_data_tvalid,
    output logic [31:0]          o_axi4s_data_tdata,
    output logic                 o_axi4s_data_tlast,
    input  logic                 i_axi4s_data_tready,
    output logic                 o_busy,
    output logic                 o_frame_done
);
    import fft_feed_pkg::*;

    localparam int AW = LOGS_FFT_LEN;
    localparam int N  = 1 << LOGS_FFT_LEN;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   wr_cnt;
    logic [AW:0]     rd_cnt;
    logic [15:0]     frame_mem [N];
    logic [15:0]     rd_data;
    logic            rd_pending;
    logic            rd_last;
    logic            rd_issue;
    logic            fill_write;
    logic            fill_last;
    logic            xfer;
    logic            last_xfer;
    logic            skid_valid;
    logic [16:0]     skid_data;
    logic [1:0]      skid_count;

    assign fill_write = (state == ST_FILL) && i_adc_vld;
    assign fill_last  = fill_write && (wr_cnt == AW'(N - 1));
    assign xfer       = skid_valid && i_axi4s_data_tready;
    assign last_xfer  = xfer && skid_data[16];

    // A read may issue while the skid plus the in-flight read, after this
    // cycle's pop, still leaves a free slot; rd_cnt[AW] marks all N issued.
    assign rd_issue = (state == ST_SEND) && !rd_cnt[AW] &&
                      (({1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, xfer}) < 3'd2);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) state <= ST_CFG;
        else       state <= next_state;
    end

    // Next-state logic: one config cycle, then arm / fill / send.
    // NOTE: next_state defaults to state first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_CFG:  next_state = ST_IDLE;
            ST_IDLE: if (i_start) next_state = ST_FILL;
            ST_FILL: if (fill_last) next_state = ST_SEND;
            ST_SEND: if (last_xfer) next_state = i_continuous ? ST_FILL : ST_IDLE;
            default: next_state = ST_CFG;
        endcase
    end

    // State-decoded outputs; cfg strobe is masked while reset is held so it
    // reads 0 in reset and fires in the first clock after release.
    always_comb begin
        o_axi4s_cfg_tvalid = (state == ST_CFG) && !i_rst;
        o_busy             = (state == ST_FILL) || (state == ST_SEND);
    end

    // Write pointer: held at zero outside FILL so every frame starts at 0.
    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst)                 wr_cnt <= '0;
        else if (state != ST_FILL) wr_cnt <= '0;
        else if (i_adc_vld)        wr_cnt <= wr_cnt + 1'b1;
    end

    // Frame RAM: converted writes during FILL, registered reads during SEND.
    // NOTE: the buffer has no reset so it maps onto block RAM; each entry is written before it is read.
    always_ff @(posedge i_aclk) begin
        if (fill_write) frame_mem[wr_cnt] <= adc_to_q15(16'(i_adc_data), ADC_WIDTH);
        if (rd_issue)   rd_data <= frame_mem[rd_cnt[AW-1:0]];
    end

    // Read pointer and the valid/last flags that travel with the RAM output.
    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            rd_cnt     <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
            rd_last    <= rd_issue && (rd_cnt[AW-1:0] == AW'(N - 1));
            if (state != ST_SEND) rd_cnt <= '0;
            else if (rd_issue)    rd_cnt <= rd_cnt + 1'b1;
        end
    end

    fft_feed_skid #(
        .WIDTH(17)
    ) u_skid (
        .clk      (i_aclk),
        .rst      (i_rst),
        .in_valid (rd_pending),
        .in_data  ({rd_last, rd_data}),
        .out_valid(skid_valid),
        .out_data (skid_data),
        .out_ready(i_axi4s_data_tready),
        .count    (skid_count)
    );

    // Data lane: real part from the skid head, imaginary part constant zero.
    always_comb begin
        o_axi4s_data_tdata                  = '0;
        o_axi4s_data_tdata[RE_LSB +: 16]    = skid_data[15:0];
        o_axi4s_data_tdata[IM_LSB +: 16]    = 16'h0000;
    end

    assign o_axi4s_data_tvalid = skid_valid;
    assign o_axi4s_data_tlast  = skid_valid && skid_data[16];
    assign o_axi4s_cfg_tdata   = FFT_DIR;
    assign o_frame_done        = last_xfer;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: a scoreboard queue receives the
// expected beat for every sample the feeder should store; a negedge monitor
// pops and compares on each handshake and checks stall stability.
module tb_fft_frame_feeder;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adc_data = 8'h00;
    logic        adc_vld = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        tready;
    logic        cfg_tvalid;
    logic        cfg_tdata;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        busy;
    logic        frame_done;

    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    logic [7:0]  ramp = 8'h00;
    int hs_cnt, done_cnt, last_cnt, stall_cnt;
    int first_hs_cyc, last_hs_cyc, first_vld_cyc;
    bit tready_rand = 1'b0;
    bit tready_level = 1'b0;

    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    fft_frame_feeder #(
        .ADC_WIDTH   (8),
        .LOGS_FFT_LEN(10),
        .FFT_DIR     (1'b1)
    ) dut (
        .i_aclk             (clk),
        .i_rst              (rst),
        .i_adc_data         (adc_data),
        .i_adc_vld          (adc_vld),
        .i_start            (start),
        .i_continuous       (continuous),
        .o_axi4s_cfg_tvalid (cfg_tvalid),
        .o_axi4s_cfg_tdata  (cfg_tdata),
        .o_axi4s_data_tvalid(tvalid),
        .o_axi4s_data_tdata (tdata),
        .o_axi4s_data_tlast (tlast),
        .i_axi4s_data_tready(tready),
        .o_busy             (busy),
        .o_frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // tready is driven just after each rising edge, either held or random (~30% low).
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tready_rand) tready = ($urandom_range(0, 99) >= 30);
            else             tready = tready_level;
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, spurious frame_done.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                stall_cnt++;
                total++;
                if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last)
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, held v=1 d=%h l=%b",
                             tvalid, tdata, tlast, prev_data, prev_last);
                else
                    pass_cnt++;
            end
            if (tvalid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (tvalid === 1'b1 && tready === 1'b1) begin
                if (hs_cnt == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
                if (tlast === 1'b1) last_cnt++;
                if (frame_done === 1'b1) done_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_unexpected: got last=%b data=%h, expected no beat", tlast, tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e || frame_done !== e[32])
                        $display("FAIL beat %0d: got last=%b data=%h done=%b, expected last=%b data=%h done=%b",
                                 hs_cnt - 1, tlast, tdata, frame_done, e[32], e[31:0], e[32]);
                    else
                        pass_cnt++;
                end
            end else if (frame_done !== 1'b0) begin
                total++;
                $display("FAIL spurious_done: got frame_done=%b without handshake, expected 0", frame_done);
            end
            prev_vld  = tvalid;
            prev_rdy  = tready;
            prev_data = tdata;
            prev_last = tlast;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_counters();
        hs_cnt = 0; done_cnt = 0; last_cnt = 0; stall_cnt = 0;
        first_hs_cyc = -1; last_hs_cyc = -1; first_vld_cyc = -1;
    endtask

    task automatic send_start();
        @(posedge clk);
        #1;
        start = 1'b1;
    endtask

    // Present one frame of N valid ramp samples, one every 'period' cycles,
    // optionally pulsing i_start once at sample index 'extra_k'.
    task automatic feed(input int period, input int extra_k, output int last_cyc);
        int k;
        int gap;
        bit extra_done;
        k = 0; gap = 0; extra_done = 1'b0; last_cyc = 0;
        while (k < N) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (gap >= period - 1) begin
                adc_vld  = 1'b1;
                adc_data = ramp;
                exp_q.push_back({k == N - 1, 16'h0000, ramp ^ 8'h80, 8'h00});
                ramp++;
                k++;
                gap = 0;
                last_cyc = cyc;
            end else begin
                adc_vld  = 1'b0;
                adc_data = 8'($urandom);
                gap++;
                if (k == extra_k && !extra_done) begin
                    start = 1'b1;
                    extra_done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        adc_vld = 1'b0;
        start = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 6000) begin
            @(posedge clk);
            #1;
            b++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tready_level = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cfg_tvalid, tvalid, tlast, busy, frame_done} !== 5'b0)
            $display("FAIL reset_ctrl: got cfg_v/v/last/busy/done=%b, expected 00000",
                     {cfg_tvalid, tvalid, tlast, busy, frame_done});
        else pass_cnt++;
        total++;
        if (tdata !== 32'h0 || cfg_tdata !== 1'b1)
            $display("FAIL reset_data: got tdata=%h cfg_tdata=%b, expected 00000000 1", tdata, cfg_tdata);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cfg_tvalid !== 1'b1 || cfg_tdata !== 1'b1 || tvalid !== 1'b0)
            $display("FAIL cfg_pulse: got cfg_v=%b cfg_d=%b v=%b, expected 1 1 0", cfg_tvalid, cfg_tdata, tvalid);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (cfg_tvalid !== 1'b0)
            $display("FAIL cfg_once: got cfg_v=%b, expected 0", cfg_tvalid);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total++;
        if ({cfg_tvalid, tvalid, busy} !== 3'b0)
            $display("FAIL idle_quiet: got cfg_v/v/busy=%b, expected 000", {cfg_tvalid, tvalid, busy});
        else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        int lc;
        clear_counters();
        ramp = 8'h00;
        tready_level = 1'b1;
        send_start();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL busy_pre: got %b, expected 0", busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b, expected 1", busy);
        else pass_cnt++;
        feed(1, -1, lc);
        // Extra valid samples during SEND must be dropped.
        repeat (4) begin
            @(posedge clk);
            #1;
            adc_vld = 1'b1;
            adc_data = 8'($urandom);
        end
        @(posedge clk);
        #1;
        adc_vld = 1'b0;
        drain();
        total++;
        if (exp_q.size() != 0 || hs_cnt != N)
            $display("FAIL basic_count: got left=%0d beats=%0d, expected 0 %0d", exp_q.size(), hs_cnt, N);
        else pass_cnt++;
        total++;
        if (first_vld_cyc != lc + 3)
            $display("FAIL send_latency: got first tvalid cycle %0d, expected %0d", first_vld_cyc, lc + 3);
        else pass_cnt++;
        total++;
        if (first_hs_cyc != first_vld_cyc || last_hs_cyc - first_hs_cyc != N - 1)
            $display("FAIL gap_free: got span %0d, expected %0d", last_hs_cyc - first_hs_cyc, N - 1);
        else pass_cnt++;
        total++;
        if (done_cnt != 1 || last_cnt != 1)
            $display("FAIL basic_last: got done=%0d last=%0d, expected 1 1", done_cnt, last_cnt);
        else pass_cnt++;
        total++;
        if (busy !== 1'b0 || tvalid !== 1'b0)
            $display("FAIL basic_idle: got busy=%b v=%b, expected 0 0", busy, tvalid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int lc;
        clear_counters();
        ramp = 8'h00;
        tready_rand = 1'b1;
        send_start();
        feed(1, -1, lc);
        drain();
        tready_rand = 1'b0;
        total++;
        if (exp_q.size() != 0 || hs_cnt != N)
            $display("FAIL bp_count: got left=%0d beats=%0d, expected 0 %0d", exp_q.size(), hs_cnt, N);
        else pass_cnt++;
        total++;
        if (done_cnt != 1 || last_cnt != 1 || stall_cnt == 0)
            $display("FAIL bp_last: got done=%0d last=%0d stalls=%0d, expected 1 1 >0", done_cnt, last_cnt, stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_sparse_vld();
        int lc;
        clear_counters();
        ramp = 8'h00;
        send_start();
        feed(3, 500, lc);
        drain();
        total++;
        if (exp_q.size() != 0 || hs_cnt != N || done_cnt != 1)
            $display("FAIL sparse: got left=%0d beats=%0d done=%0d, expected 0 %0d 1",
                     exp_q.size(), hs_cnt, done_cnt, N);
        else pass_cnt++;
        total++;
        if (busy !== 1'b0) $display("FAIL sparse_idle: got busy=%b, expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_continuous();
        int lc;
        int b;
        clear_counters();
        ramp = 8'h00;
        continuous = 1'b1;
        send_start();
        feed(1, -1, lc);
        for (int f = 1; f <= 2; f++) begin
            b = 0;
            while (done_cnt < f && b < 4000) begin
                @(posedge clk);
                #1;
                b++;
            end
            total++;
            if (done_cnt < f || busy !== 1'b1)
                $display("FAIL cont_rearm %0d: got done=%0d busy=%b, expected %0d 1", f, done_cnt, busy, f);
            else pass_cnt++;
            feed(1, -1, lc);
            if (f == 2) continuous = 1'b0;
        end
        drain();
        total++;
        if (exp_q.size() != 0 || hs_cnt != 3 * N)
            $display("FAIL cont_count: got left=%0d beats=%0d, expected 0 %0d", exp_q.size(), hs_cnt, 3 * N);
        else pass_cnt++;
        total++;
        if (done_cnt != 3 || last_cnt != 3 || busy !== 1'b0)
            $display("FAIL cont_done: got done=%0d last=%0d busy=%b, expected 3 3 0", done_cnt, last_cnt, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_send();
        int lc;
        int b;
        clear_counters();
        ramp = 8'h00;
        send_start();
        feed(1, -1, lc);
        b = 0;
        while (hs_cnt < 500 && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        total++;
        if (hs_cnt < 500) $display("FAIL mid_send_reach: got beats=%0d, expected >=500", hs_cnt);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if ({cfg_tvalid, tvalid, tlast, busy, frame_done} !== 5'b0 || tdata !== 32'h0)
            $display("FAIL mid_reset: got ctrl=%b tdata=%h, expected 00000 00000000",
                     {cfg_tvalid, tvalid, tlast, busy, frame_done}, tdata);
        else pass_cnt++;
        total++;
        if (last_cnt != 0) $display("FAIL partial_tlast: got %0d, expected 0", last_cnt);
        else pass_cnt++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cfg_tvalid !== 1'b1) $display("FAIL cfg_reissue: got %b, expected 1", cfg_tvalid);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        clear_counters();
        ramp = 8'h00;
        send_start();
        feed(1, -1, lc);
        drain();
        total++;
        if (exp_q.size() != 0 || hs_cnt != N || done_cnt != 1 || last_cnt != 1)
            $display("FAIL post_reset_frame: got left=%0d beats=%0d done=%0d last=%0d, expected 0 %0d 1 1",
                     exp_q.size(), hs_cnt, done_cnt, last_cnt, N);
        else pass_cnt++;
    endtask

    initial begin
        clear_counters();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_sparse_vld();
        test_continuous();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
